// File: rtl/pe_loop_sequencer.sv
// Loop-nest controller for the PE activation/weight RAM: steps load -> per-channel
// compute -> PPU write-back over K groups and layers, publishing offsets and remain flags.
module pe_loop_sequencer #(
  parameter  int I     = 4,
  parameter  int F     = 4,
  parameter  int MAX_A = 256,
  parameter  int MAX_W = 64,
  parameter  int MAX_C = 16,
  parameter  int MAX_K = 16,
  parameter  int MAX_L = 8,
  localparam int AW    = $clog2(MAX_A) + 1,
  localparam int WW    = $clog2(MAX_W) + 1,
  localparam int CW    = $clog2(MAX_C),
  localparam int KW    = $clog2(MAX_K),
  localparam int LW    = $clog2(MAX_L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW:0]   cfg_num_layers,
  input  logic [CW:0]   cfg_num_c,
  input  logic [KW:0]   cfg_num_k,
  input  logic [AW-1:0] cfg_num_a,
  input  logic [WW-1:0] cfg_num_w,
  input  logic          load_done,
  input  logic          ppu_done,
  input  logic          busy,
  output logic [2:0]    state,
  output logic [LW-1:0] cur_layer,
  output logic [CW-1:0] cur_c,
  output logic [KW-1:0] cur_k,
  output logic [AW-1:0] cur_a,
  output logic [WW-1:0] cur_w,
  output logic [AW-1:0] remain_a,
  output logic [WW-1:0] remain_w,
  output logic          flag_remain_a,
  output logic          flag_remain_w,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_PPU     = 3'd3,
    S_SETUP   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam logic [AW:0]   I_AX  = I[AW:0];
  localparam logic [WW:0]   F_WX  = F[WW:0];
  localparam logic [AW-1:0] I_A   = I[AW-1:0];
  localparam logic [WW-1:0] F_W   = F[WW-1:0];
  localparam logic [CW:0]   C_ONE = 1;
  localparam logic [KW:0]   K_ONE = 1;
  localparam logic [LW:0]   L_ONE = 1;

  state_e        state_q, state_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [CW-1:0] c_q, c_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] a_q, a_d, num_a_lat_q, num_a_lat_d;
  logic [WW-1:0] w_q, w_d, num_w_lat_q, num_w_lat_d;

  // Sums carry one extra bit so the step compare cannot wrap near the maxima.
  logic [AW:0] a_step;
  logic [WW:0] w_step;
  logic [CW:0] c_inc;
  logic [KW:0] k_inc;
  logic [LW:0] l_inc;
  logic        chan_end;

  assign a_step = {1'b0, a_q} + I_AX;
  assign w_step = {1'b0, w_q} + F_WX;
  assign c_inc  = {1'b0, c_q} + C_ONE;
  assign k_inc  = {1'b0, k_q} + K_ONE;
  assign l_inc  = {1'b0, layer_q} + L_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      c_q         <= '0;
      k_q         <= '0;
      a_q         <= '0;
      w_q         <= '0;
      num_a_lat_q <= '0;
      num_w_lat_q <= '0;
    end else if (!busy) begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      c_q         <= c_d;
      k_q         <= k_d;
      a_q         <= a_d;
      w_q         <= w_d;
      num_a_lat_q <= num_a_lat_d;
      num_w_lat_q <= num_w_lat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    c_d         = c_q;
    k_d         = k_q;
    a_d         = a_q;
    w_d         = w_q;
    num_a_lat_d = num_a_lat_q;
    num_w_lat_d = num_w_lat_q;
    chan_end    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_LOAD;
        layer_d     = '0;
        c_d         = '0;
        k_d         = '0;
        a_d         = '0;
        w_d         = '0;
        num_a_lat_d = '0;
        num_w_lat_d = '0;
      end
      S_LOAD: if (load_done) begin
        state_d = S_SETUP;
        c_d     = '0;
        k_d     = '0;
      end
      S_SETUP: begin
        num_a_lat_d = cfg_num_a;
        num_w_lat_d = cfg_num_w;
        a_d         = '0;
        w_d         = '0;
        // An empty channel contributes nothing, so fall straight to the next one.
        if (cfg_num_a == '0 || cfg_num_w == '0) chan_end = 1'b1;
        else                                    state_d  = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (a_step < {1'b0, num_a_lat_q}) begin
          a_d = a_step[AW-1:0];
        end else if (w_step < {1'b0, num_w_lat_q}) begin
          a_d = '0;
          w_d = w_step[WW-1:0];
        end else begin
          chan_end = 1'b1;
        end
      end
      S_PPU: if (ppu_done) begin
        if (k_inc < cfg_num_k) begin
          k_d     = k_inc[KW-1:0];
          c_d     = '0;
          state_d = S_SETUP;
        end else if (l_inc < cfg_num_layers) begin
          layer_d = l_inc[LW-1:0];
          k_d     = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (chan_end) begin
      if (c_inc < cfg_num_c) begin
        c_d     = c_inc[CW-1:0];
        state_d = S_SETUP;
      end else begin
        state_d = S_PPU;
      end
    end
  end

  assign state         = state_q;
  assign cur_layer     = layer_q;
  assign cur_c         = c_q;
  assign cur_k         = k_q;
  assign cur_a         = a_q;
  assign cur_w         = w_q;
  assign remain_a      = num_a_lat_q - a_q;
  assign remain_w      = num_w_lat_q - w_q;
  assign flag_remain_a = (remain_a >= I_A);
  assign flag_remain_w = (remain_w >= F_W);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Directed bench for pe_loop_sequencer: per-cycle traces of state/counters against
// hand-derived sequences, plus stall, reset and dropped-start cases.
module tb_pe_loop_sequencer;
  localparam int I = 4, F = 2;
  localparam int AW = 9, WW = 7, CW = 4, KW = 4, LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, load_done = 1'b0, ppu_done = 1'b0, busy = 1'b0;
  logic [LW:0]   cfg_num_layers = '0;
  logic [CW:0]   cfg_num_c = '0;
  logic [KW:0]   cfg_num_k = '0;
  logic [AW-1:0] cfg_num_a;
  logic [WW-1:0] cfg_num_w = '0;
  logic [2:0]    state;
  logic [LW-1:0] cur_layer;
  logic [CW-1:0] cur_c;
  logic [KW-1:0] cur_k;
  logic [AW-1:0] cur_a, remain_a;
  logic [WW-1:0] cur_w, remain_w;
  logic          flag_remain_a, flag_remain_w, done;

  logic [AW-1:0] a_tab [16];
  always_comb cfg_num_a = a_tab[cur_c];

  pe_loop_sequencer #(.I(I), .F(F)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_num_layers(cfg_num_layers), .cfg_num_c(cfg_num_c), .cfg_num_k(cfg_num_k),
    .cfg_num_a(cfg_num_a), .cfg_num_w(cfg_num_w),
    .load_done(load_done), .ppu_done(ppu_done), .busy(busy),
    .state(state), .cur_layer(cur_layer), .cur_c(cur_c), .cur_k(cur_k),
    .cur_a(cur_a), .cur_w(cur_w), .remain_a(remain_a), .remain_w(remain_w),
    .flag_remain_a(flag_remain_a), .flag_remain_w(flag_remain_w), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_done = 0;
  logic auto_ev = 1'b1, spam_start = 1'b0;

  typedef struct { logic [2:0] st; int layer, c, k, a, w; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock: sample point is 1ns after the edge; event inputs react to the new state.
  task automatic cyc();
    @(posedge clk); #1;
    if (done) n_done++;
    if (auto_ev) begin
      load_done = (state == 3'd1);
      ppu_done  = (state == 3'd3);
    end
    start = spam_start && (state == 3'd2);
  endtask

  task automatic push(input logic [2:0] st, input int layer, c, k, a, w);
    exp_t e;
    e.st = st; e.layer = layer; e.c = c; e.k = k; e.a = a; e.w = w;
    exp_q.push_back(e);
  endtask

  // Pulses start and then walks the expected trace, starting with the LOAD cycle.
  task automatic run_trace(input string tag);
    exp_t e;
    int n = 0;
    start = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc();
      chk($sformatf("%s[%0d].state", tag, n), 32'(state), 32'(e.st));
      chk($sformatf("%s[%0d].layer", tag, n), 32'(cur_layer), e.layer);
      chk($sformatf("%s[%0d].c", tag, n), 32'(cur_c), e.c);
      chk($sformatf("%s[%0d].k", tag, n), 32'(cur_k), e.k);
      if (e.a >= 0) chk($sformatf("%s[%0d].a", tag, n), 32'(cur_a), e.a);
      if (e.w >= 0) chk($sformatf("%s[%0d].w", tag, n), 32'(cur_w), e.w);
      n++;
    end
  endtask

  task automatic cfg(input int l, c, k, w);
    cfg_num_layers = l[LW:0]; cfg_num_c = c[CW:0]; cfg_num_k = k[KW:0]; cfg_num_w = w[WW-1:0];
  endtask

  initial begin
    foreach (a_tab[i]) a_tab[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(state), 0);
    chk("rst.a", 32'(cur_a), 0);
    chk("rst.done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    cyc();

    // 1: a-inner/w-outer stepping and remain flags, num_a=5 num_w=3
    cfg(1, 1, 1, 3); a_tab[0] = 5;
    start = 1'b1;
    cyc(); chk("t1.load", 32'(state), 1);
    cyc(); chk("t1.setup", 32'(state), 4);
    begin
      int ea[4] = '{0, 4, 0, 4};
      int ew[4] = '{0, 0, 2, 2};
      int ra[4] = '{5, 1, 5, 1};
      int rw[4] = '{3, 3, 1, 1};
      int fa[4] = '{1, 0, 1, 0};
      int fw[4] = '{1, 1, 0, 0};
      for (int i = 0; i < 4; i++) begin
        cyc();
        chk($sformatf("t1.st%0d", i), 32'(state), 2);
        chk($sformatf("t1.a%0d", i), 32'(cur_a), ea[i]);
        chk($sformatf("t1.w%0d", i), 32'(cur_w), ew[i]);
        chk($sformatf("t1.ra%0d", i), 32'(remain_a), ra[i]);
        chk($sformatf("t1.rw%0d", i), 32'(remain_w), rw[i]);
        chk($sformatf("t1.fa%0d", i), 32'(flag_remain_a), fa[i]);
        chk($sformatf("t1.fw%0d", i), 32'(flag_remain_w), fw[i]);
      end
    end
    cyc(); chk("t1.ppu", 32'(state), 3);
    cyc(); chk("t1.done", 32'(done), 1);
    cyc(); chk("t1.idle", 32'(state), 0);
    chk("t1.done_off", 32'(done), 0);

    // 2: three channels, channel 1 empty is a single SETUP with no COMPUTE
    cfg(1, 3, 1, 2); a_tab[0] = 4; a_tab[1] = 0; a_tab[2] = 8;
    push(1, 0, 0, 0, -1, -1); push(4, 0, 0, 0, -1, -1); push(2, 0, 0, 0, 0, 0);
    push(4, 0, 1, 0, -1, -1); push(4, 0, 2, 0, -1, -1);
    push(2, 0, 2, 0, 0, 0);   push(2, 0, 2, 0, 4, 0);
    push(3, 0, 2, 0, -1, -1); push(5, 0, 2, 0, -1, -1); push(0, 0, 2, 0, -1, -1);
    run_trace("t2");

    // 3: two K groups, two layers; layer parity flips at the second LOAD
    cfg(2, 1, 2, 2); a_tab[0] = 4;
    n_done = 0;
    for (int l = 0; l < 2; l++) begin
      push(1, l, 0, 0, -1, -1);
      for (int k = 0; k < 2; k++) begin
        push(4, l, 0, k, -1, -1); push(2, l, 0, k, 0, 0); push(3, l, 0, k, -1, -1);
      end
    end
    push(5, 1, 0, 1, -1, -1); push(0, 1, 0, 1, -1, -1);
    run_trace("t3");
    chk("t3.done_cnt", n_done, 1);

    // 4: 3-cycle stall mid-COMPUTE with an early ppu_done
    cfg(1, 1, 1, 2); a_tab[0] = 12;
    start = 1'b1;
    cyc(); cyc(); cyc();
    chk("t4.a0", 32'(cur_a), 0);
    auto_ev = 1'b0; busy = 1'b1; ppu_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t4.frz_st%0d", i), 32'(state), 2);
      chk($sformatf("t4.frz_a%0d", i), 32'(cur_a), 0);
    end
    busy = 1'b0; ppu_done = 1'b0;
    cyc(); chk("t4.a1", 32'(cur_a), 4);
    cyc(); chk("t4.a2", 32'(cur_a), 8);
    cyc(); chk("t4.ppu", 32'(state), 3);
    cyc(); chk("t4.ppu_hold", 32'(state), 3);
    ppu_done = 1'b1;
    cyc(); chk("t4.done", 32'(state), 5);
    ppu_done = 1'b0; auto_ev = 1'b1;
    cyc(); chk("t4.idle", 32'(state), 0);

    // 5: async reset during PPU, then a clean run
    auto_ev = 1'b0;
    start = 1'b1;
    cyc(); load_done = 1'b1;
    cyc(); load_done = 1'b0;
    repeat (4) cyc();
    chk("t5.ppu", 32'(state), 3);
    chk("t5.ppu_a", 32'(cur_a), 8);
    #2 rst_n = 1'b0; #1;
    chk("t5.rst_state", 32'(state), 0);
    chk("t5.rst_a", 32'(cur_a), 0);
    chk("t5.rst_ra", 32'(remain_a), 0);
    chk("t5.rst_done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1; auto_ev = 1'b1;
    cyc();
    push(1, 0, 0, 0, -1, -1); push(4, 0, 0, 0, -1, -1);
    push(2, 0, 0, 0, 0, 0); push(2, 0, 0, 0, 4, 0); push(2, 0, 0, 0, 8, 0);
    push(3, 0, 0, 0, -1, -1); push(5, 0, 0, 0, -1, -1); push(0, 0, 0, 0, -1, -1);
    run_trace("t5");

    // 6: start held during COMPUTE has no effect
    spam_start = 1'b1;
    push(1, 0, 0, 0, -1, -1); push(4, 0, 0, 0, -1, -1);
    push(2, 0, 0, 0, 0, 0); push(2, 0, 0, 0, 4, 0); push(2, 0, 0, 0, 8, 0);
    push(3, 0, 0, 0, -1, -1); push(5, 0, 0, 0, -1, -1); push(0, 0, 0, 0, -1, -1);
    run_trace("t6");
    spam_start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
